// File: rtl/svcs_frame_pkg.sv
// svcs_frame_pkg
//   Shared types and header layout for the SVCS message framer.
//   - msg_type_e    : payload type code carried in header bits [1:0]
//   - frame_state_e : framer FSM states
//   - hdr_pack()    : builds a header word of any width up to HDR_MAX_W
package svcs_frame_pkg;

    typedef enum logic [1:0] {
        MT_INT   = 2'd0,
        MT_REAL  = 2'd1,
        MT_INTV  = 2'd2,
        MT_REALV = 2'd3
    } msg_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
        ST_TRL
    } frame_state_e;

    // Header layout: channel id in the top byte, size above the type code.
    localparam int HDR_TYPE_LSB = 0;
    localparam int HDR_SIZE_LSB = 2;
    localparam int HDR_CH_W     = 8;
    localparam int HDR_MAX_W    = 256;
    localparam int SIZE_MAX_W   = 16;

    // data_w is always a parameter at the call site, so the variable
    // shift folds to constant wiring.
    function automatic logic [HDR_MAX_W-1:0] hdr_pack(
        input int unsigned            data_w,
        input logic [HDR_CH_W-1:0]    ch,
        input logic [SIZE_MAX_W-1:0]  size,
        input msg_type_e              t
    );
        logic [HDR_MAX_W-1:0] w;
        w = '0;
        w = w | (HDR_MAX_W'(ch) << (data_w - HDR_CH_W));
        w = w | (HDR_MAX_W'(size) << HDR_SIZE_LSB);
        w = w | (HDR_MAX_W'(t) << HDR_TYPE_LSB);
        return w;
    endfunction

endpackage

// File: rtl/svcs_rr_arb.sv
// svcs_rr_arb
//   Round-robin arbiter. The channel after the last granted one has the
//   highest priority; after reset channel 0 is highest.
//   Ports:
//     clk, rst  : clock, async active-high reset
//     req       : per-requestor request
//     upd       : commit the current grant (advance pointer)
//     gnt_idx   : index of the granted requestor
//     gnt_any   : at least one request present
module svcs_rr_arb #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             upd,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] ptr_q;

    // Scan from the pointer, wrapping; first hit wins.
    always_comb begin
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) j = j - N;
            if (!gnt_any && req[j]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (upd && gnt_any) begin
            if (gnt_idx == IDX_W'(N-1)) ptr_q <= '0;
            else                        ptr_q <= gnt_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/svcs_frame_tx.sv
// svcs_frame_tx
//   Multi-channel message framer. Serialises one request at a time onto a
//   valid/ready word stream as header, payload elements and an optional
//   XOR checksum trailer.
//   Ports:
//     clk, rst                       : clock, async active-high reset
//     ch_valid/ch_ready              : per-channel handshake
//     ch_type/ch_size/ch_data        : per-channel request and current element
//     out_valid/out_ready            : output stream handshake
//     out_data/out_last/out_ch       : output word, end-of-frame, channel id
//     err_size                       : sticky, a vector size was clamped
module svcs_frame_tx
    import svcs_frame_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int MAX_ELEM = 16,
    parameter  int NUM_CH   = 2,
    parameter  bit CHK_EN   = 1'b1,
    localparam int SIZE_W   = $clog2(MAX_ELEM + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ch_valid,
    output logic [NUM_CH-1:0]              ch_ready,
    input  logic [NUM_CH-1:0][1:0]         ch_type,
    input  logic [NUM_CH-1:0][SIZE_W-1:0]  ch_size,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_last,
    output logic [7:0]                     out_ch,
    output logic                           err_size
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    frame_state_e      state_q, state_d;
    msg_type_e         typ_q;
    logic [SIZE_W-1:0] size_q;
    logic [IDX_W-1:0]  gidx_q;
    logic [SIZE_W-1:0] cnt_q;
    logic [DATA_W-1:0] chk_q;
    logic              err_q;

    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              arb_upd;

    logic [1:0]        req_type;
    logic [SIZE_W-1:0] req_size;
    logic [SIZE_W-1:0] eff_size;
    logic              clamp;
    logic              hs;
    logic              last_elem;
    logic [DATA_W-1:0] hdr_word;

    svcs_rr_arb #(
        .N     (NUM_CH),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (ch_valid),
        .upd     (arb_upd),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Scalars always carry one element; vectors are clamped to MAX_ELEM.
    always_comb begin
        req_type = ch_type[gnt_idx];
        req_size = ch_size[gnt_idx];
        eff_size = req_size;
        clamp    = 1'b0;
        if (!req_type[1]) begin
            eff_size = SIZE_W'(1);
        end else if (req_size > SIZE_W'(MAX_ELEM)) begin
            eff_size = SIZE_W'(MAX_ELEM);
            clamp    = 1'b1;
        end
    end

    assign hdr_word  = DATA_W'(hdr_pack(DATA_W, HDR_CH_W'(gidx_q),
                                        SIZE_MAX_W'(size_q), typ_q));
    assign last_elem = (cnt_q == size_q - SIZE_W'(1));
    assign arb_upd   = (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        ch_ready  = '0;
        hs        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) state_d = ST_HDR;
            end
            ST_HDR: begin
                out_valid = 1'b1;
                out_data  = hdr_word;
                hs        = out_ready;
                if (size_q == '0) begin
                    // Empty vector: the header handshake retires the request.
                    ch_ready[gidx_q] = out_ready;
                    out_last         = !CHK_EN;
                    if (hs) state_d = CHK_EN ? ST_TRL : ST_IDLE;
                end else if (hs) begin
                    state_d = ST_BODY;
                end
            end
            ST_BODY: begin
                // Elements pass straight through from the granted producer.
                out_valid        = ch_valid[gidx_q];
                out_data         = ch_data[gidx_q];
                ch_ready[gidx_q] = out_ready;
                out_last         = last_elem && !CHK_EN;
                hs               = out_valid && out_ready;
                if (hs && last_elem) state_d = CHK_EN ? ST_TRL : ST_IDLE;
            end
            ST_TRL: begin
                out_valid = 1'b1;
                out_data  = chk_q;
                out_last  = 1'b1;
                hs        = out_ready;
                if (hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            typ_q   <= MT_INT;
            size_q  <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            chk_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any) begin
                        typ_q  <= msg_type_e'(req_type);
                        size_q <= eff_size;
                        gidx_q <= gnt_idx;
                        cnt_q  <= '0;
                        chk_q  <= '0;
                        if (clamp) err_q <= 1'b1;
                    end
                end
                ST_BODY: begin
                    if (hs) begin
                        cnt_q <= cnt_q + SIZE_W'(1);
                        chk_q <= chk_q ^ ch_data[gidx_q];
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_ch   = 8'(gidx_q);
    assign err_size = err_q;

endmodule

// File: tb/tb_svcs_frame_tx.sv
module tb_svcs_frame_tx;
    import svcs_frame_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           ch_valid, ch_ready;
    logic [1:0][1:0]      ch_type;
    logic [1:0][4:0]      ch_size;
    logic [1:0][31:0]     ch_data;
    logic                 out_valid, out_ready, out_last, err_size;
    logic [31:0]          out_data;
    logic [7:0]           out_ch;

    // second instance without checksum trailer
    logic [1:0]           n_valid, n_ready;
    logic [1:0][1:0]      n_type;
    logic [1:0][4:0]      n_size;
    logic [1:0][31:0]     n_data;
    logic                 n_ovalid, n_oready, n_olast, n_err;
    logic [31:0]          n_odata;
    logic [7:0]           n_och;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    svcs_frame_tx #(.DATA_W(32), .MAX_ELEM(16), .NUM_CH(2), .CHK_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_type(ch_type), .ch_size(ch_size), .ch_data(ch_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_ch(out_ch), .err_size(err_size)
    );

    svcs_frame_tx #(.DATA_W(32), .MAX_ELEM(16), .NUM_CH(2), .CHK_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .ch_valid(n_valid), .ch_ready(n_ready),
        .ch_type(n_type), .ch_size(n_size), .ch_data(n_data),
        .out_valid(n_ovalid), .out_ready(n_oready), .out_data(n_odata),
        .out_last(n_olast), .out_ch(n_och), .err_size(n_err)
    );

    typedef struct {
        int          ch;
        logic [1:0]  typ;
        logic [4:0]  size;
        int          nrdy;
        int          nexp;
        logic [31:0] el  [16];
        logic [31:0] exp [18];
    } frame_t;

    frame_t tbl [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // nel data words between header and trailer; up to four given inline
    function automatic frame_t mk(input int ch, input logic [1:0] typ, input logic [4:0] size,
                                  input int nel, input int nrdy, input logic [31:0] hdr,
                                  input logic [31:0] trl, input logic [31:0] e0,
                                  input logic [31:0] e1, input logic [31:0] e2,
                                  input logic [31:0] e3);
        frame_t f;
        for (int i = 0; i < 16; i++) f.el[i] = '0;
        for (int i = 0; i < 18; i++) f.exp[i] = '0;
        f.ch = ch; f.typ = typ; f.size = size; f.nrdy = nrdy; f.nexp = nel + 2;
        f.el[0] = e0; f.el[1] = e1; f.el[2] = e2; f.el[3] = e3;
        f.exp[0] = hdr;
        for (int i = 0; i < nel && i < 4; i++) f.exp[i+1] = f.el[i];
        f.exp[nel+1] = trl;
        return f;
    endfunction

    // Call just after a negedge; returns just after a negedge with DUT idle.
    task automatic play(input frame_t f, input bit stall);
        int w = 0, k = 0, cyc = 0, rdy = 0, first = -1;
        bit pstall = 1'b0, acc;
        logic [31:0] pd = '0;
        ch_type[f.ch]  = f.typ;
        ch_size[f.ch]  = f.size;
        ch_data[f.ch]  = f.el[0];
        ch_valid[f.ch] = 1'b1;
        while (w < f.nexp && cyc < 400) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (pstall) check("stall_hold", out_data, pd);
            if (out_valid) begin
                if (first < 0) first = cyc;
                if (out_ready) begin
                    check("word", out_data, f.exp[w]);
                    check("last", 32'(out_last), 32'(w == f.nexp - 1));
                    check("out_ch", 32'(out_ch), 32'(f.ch));
                    w++;
                end
            end
            pstall = out_valid && !out_ready;
            pd     = out_data;
            acc    = ch_ready[f.ch] && ch_valid[f.ch];
            @(negedge clk);
            if (acc) begin
                rdy++; k++;
                if (k >= f.nrdy) ch_valid[f.ch] = 1'b0;
                else             ch_data[f.ch]  = f.el[k];
            end
            cyc++;
        end
        if (cyc >= 400) begin
            nvec++; nfail++;
            $display("FAIL frame_timeout: got %0d words want %0d", w, f.nexp);
        end
        check("hdr_latency", 32'(first), 32'd1);
        check("ready_pulses", 32'(rdy), 32'(f.nrdy));
        out_ready = 1'b1;
        #1;
        check("idle_gap", 32'(out_valid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        ch_valid = '0; ch_type = '0; ch_size = '0; ch_data = '0; out_ready = 1'b1;
        n_valid = '0; n_type = '0; n_size = '0; n_data = '0; n_oready = 1'b1;

        tbl[0] = mk(0, 2'd0, 5'd0, 1, 1, 32'h0000_0004, 32'h0000_00AB, 32'hAB, 0, 0, 0);
        tbl[1] = mk(1, 2'd2, 5'd3, 3, 3, 32'h0100_000E, 32'h7, 32'h1, 32'h2, 32'h4, 0);
        tbl[2] = mk(1, 2'd1, 5'd7, 1, 1, 32'h0100_0005, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0);
        tbl[3] = mk(0, 2'd2, 5'd0, 0, 1, 32'h0000_0002, 32'h0, 0, 0, 0, 0);
        tbl[4] = mk(1, 2'd3, 5'd2, 2, 2, 32'h0100_000B, 32'hFFFF_1234,
                    32'hF0F0_0000, 32'h0F0F_1234, 0, 0);
        tbl[5] = mk(1, 2'd3, 5'd20, 16, 16, 32'h0100_0043, 32'h10, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            tbl[5].el[k]    = 32'(k + 1);
            tbl[5].exp[k+1] = 32'(k + 1);
        end
        tbl[6] = mk(1, 2'd2, 5'd4, 4, 4, 32'h0100_0012, 32'h40,
                    32'h10, 32'h20, 32'h30, 32'h40);

        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_last",  32'(out_last), 0);
        check("rst_data",  out_data, 0);
        check("rst_ch",    32'(out_ch), 0);
        check("rst_ready", 32'(ch_ready), 0);
        check("rst_err",   32'(err_size), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // table: frame 6 runs with random output stalls
        for (int i = 0; i < 7; i++) begin
            play(tbl[i], i == 6);
            check("err_sticky", 32'(err_size), 32'(i >= 5));
        end

        // both channels requesting INT continuously: ch0, ch1, ch0
        ch_type[0] = 2'd0; ch_data[0] = 32'h11;
        ch_type[1] = 2'd0; ch_data[1] = 32'h22;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            ch_valid[1] = (c < 8);
            ch_valid[0] = (c < 11);
            #1;
            case (c)
                1: begin check("arb_h0_ch", 32'(out_ch), 0); check("arb_h0", out_data, 32'h4); end
                2: check("arb_d0", out_data, 32'h11);
                4: check("arb_gap0", 32'(out_valid), 0);
                5: begin check("arb_h1_ch", 32'(out_ch), 1); check("arb_h1", out_data, 32'h0100_0004); end
                6: check("arb_d1", out_data, 32'h22);
                8: check("arb_gap1", 32'(out_valid), 0);
                9: begin check("arb_h2_ch", 32'(out_ch), 0); check("arb_h2_v", 32'(out_valid), 1); end
                12, 13: check("arb_quiet", 32'(out_valid), 0);
                default: ;
            endcase
            @(negedge clk);
        end

        // reset in the middle of a BODY
        ch_type[0] = 2'd2; ch_size[0] = 5'd4; ch_data[0] = 32'h5A; ch_valid[0] = 1'b1;
        for (int c = 0; c < 4; c++) @(negedge clk);
        #1;
        check("pre_rst_body", 32'(out_valid), 1);
        check("pre_rst_err", 32'(err_size), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_last",  32'(out_last), 0);
        check("mid_rst_data",  out_data, 0);
        check("mid_rst_ch",    32'(out_ch), 0);
        check("mid_rst_ready", 32'(ch_ready), 0);
        check("mid_rst_err",   32'(err_size), 0);
        ch_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        play(mk(1, 2'd0, 5'd0, 1, 1, 32'h0100_0004, 32'h55, 32'h55, 0, 0, 0), 1'b0);

        // no-trailer instance: empty vector ends on header, INT ends on data
        n_type[0] = 2'd2; n_size[0] = 5'd0; n_valid[0] = 1'b1;
        #1; check("nc_idle", 32'(n_ovalid), 0);
        @(negedge clk); #1;
        check("nc_e_hdr",   n_odata, 32'h2);
        check("nc_e_last",  32'(n_olast), 1);
        check("nc_e_ready", 32'(n_ready), 32'h1);
        @(negedge clk);
        n_valid[0] = 1'b0;
        #1; check("nc_e_gap", 32'(n_ovalid), 0);
        @(negedge clk);
        n_type[1] = 2'd0; n_data[1] = 32'h77; n_valid[1] = 1'b1;
        @(negedge clk); #1;
        check("nc_i_hdr",  n_odata, 32'h0100_0004);
        check("nc_i_hlast", 32'(n_olast), 0);
        check("nc_i_ch",   32'(n_och), 1);
        @(negedge clk); #1;
        check("nc_i_data", n_odata, 32'h77);
        check("nc_i_last", 32'(n_olast), 1);
        check("nc_i_ready", 32'(n_ready), 32'h2);
        @(negedge clk);
        n_valid[1] = 1'b0;
        #1; check("nc_i_gap", 32'(n_ovalid), 0);
        check("nc_err", 32'(n_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/svcs_frame_tx.md
# svcs_frame_tx

Parametrised multi-channel message framer for the SVCS hardware side. It accepts typed scalar and vector payloads (int, real, int vector, real vector) from NUM_CH producer channels and serialises each one onto a single valid/ready word stream as one frame: a header word (type, element count, channel id), the payload elements, and an optional XOR checksum trailer. It sits between RTL producers and the socket bridge, giving hardware the framing that the software send/recv primitives perform per call.

## Interface
- DATA_W, 32: word width of payload and output stream; must be ≥ SIZE_W+10.
- MAX_ELEM, 16: largest vector length accepted; SIZE_W = $clog2(MAX_ELEM+1).
- NUM_CH, 2: producer channels, 1..256.
- CHK_EN, 1: 1 = append XOR checksum trailer word.

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ch_valid  in  NUM_CH  per-channel request/element valid.
- ch_ready  out  NUM_CH  per-channel accept.
- ch_type  in  NUM_CH×2  0=INT, 1=REAL, 2=INTV, 3=REALV.
- ch_size  in  NUM_CH×SIZE_W  element count (vectors only).
- ch_data  in  NUM_CH×DATA_W  current element.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  header / element / trailer word.
- out_last  out  1  final word of frame.
- out_ch  out  8  channel id of current frame.
- err_size  out  1  sticky: a vector size > MAX_ELEM was clamped.

## Operation
- States: IDLE, HDR, BODY, TRL.
- IDLE: if any ch_valid, round-robin arbiter picks grant (priority starts after last granted channel; after reset, channel 0 highest). Latch type, effective size, grant into registers; clear checksum; → HDR.
- Effective size: scalar types → 1 regardless of ch_size; vector → ch_size, clamped to MAX_ELEM with err_size set.
- HDR: out_valid=1; out_data = {grant[7:0] in [DATA_W-1:DATA_W-8], zeros, size in [SIZE_W+1:2], type in [1:0]}. On handshake: size>0 → BODY; size==0 → ch_ready[grant] pulses with the header handshake (retires request), then TRL if CHK_EN else IDLE, out_last on header when !CHK_EN.
- BODY: out_valid=ch_valid[grant], out_data=ch_data[grant], ch_ready[grant]=out_ready (combinational pass-through); each handshake XORs element into checksum and increments element counter. Last element → TRL if CHK_EN else IDLE.
- TRL: out_data=checksum (XOR of all elements, 0 if none), out_valid=1, out_last=1; handshake → IDLE.
- Non-granted ch_ready always 0; ch_ready never asserted in IDLE or TRL.
- Producers hold ch_valid/type/size/data stable until accepted; a request is retired by the handshake of its final element (or header for size 0).
- err_size cleared only by rst.

## Timing
- Reset: state IDLE, out_valid=0, out_last=0, out_data=0, out_ch=0, ch_ready=0, err_size=0, arbiter pointer 0, counter/checksum 0. Reset mid-frame aborts the frame; no partial trailer.
- Request to header: ch_valid seen in IDLE at edge N → header valid in cycle N+1.
- Throughput: one word/cycle with out_ready held; frame of size S occupies S+1+CHK_EN cycles plus one IDLE cycle.
- Back-to-back frames separated by exactly one IDLE cycle.
- out_ready low stalls any state; output word and out_last held stable.
- Simultaneous requests: grant order rotates; no channel is granted twice while another waits.

## Structure
- Package svcs_frame_pkg: type enum (INT/REAL/INTV/REALV), state enum, header field position localparams, header pack function.
- Sub-module svcs_rr_arb (NUM_CH requestors, one-hot/index grant, pointer updates on grant).

## Test plan
- Single INT on ch0, data 0x0000_00AB, CHK_EN=1 -> header 0x0000_0004, 0xAB, trailer 0xAB with out_last; ch_ready pulses once.
- INTV size 3 on ch1 data 1,2,4 -> header 0x0100_000E, 1,2,4, trailer 7; out_ch=1.
- ch0 and ch1 both request continuously -> frames alternate ch0,ch1,ch0; one IDLE cycle between frames.
- REALV size 20 with MAX_ELEM=16 -> header size field 16, 16 elements consumed, err_size=1 and stays 1.
- INTV size 0 -> header then trailer 0; ch_ready pulses on header handshake; with CHK_EN=0 out_last on header.
- Random out_ready stalls mid-BODY, then rst asserted mid-frame -> all outputs zero immediately, next request restarts with header.
